// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//
// Purpose : Shared types and default sizes for the I/D memory-port arbiter.
//
// Contents:
//   DEFAULT_ADDR_WIDTH : default address width of every port
//   DEFAULT_DATA_WIDTH : default data width (must be a multiple of 8)
//   state_t            : arbiter FSM states (IDLE, REQ, WAIT)
//   owner_t            : owner of the outstanding transaction (OWN_I, OWN_D)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // IDLE : nothing outstanding, a new request may be picked
    // REQ  : request presented on the memory port, waiting for m_gnt
    // WAIT : request accepted by memory, waiting for m_rvalid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//
// Purpose : Bundles the fetch (i_*), load/store (d_*) and memory (m_*)
//           handshakes around the arbiter.
//
// Modports:
//   slave  : arbiter view. Takes requests from I and D, returns gnt/rvalid/
//            rdata to them, drives the memory request, takes memory responses.
//   master : environment view (requesters + memory), exact mirror of slave.
//
// Parameters:
//   ADDR_WIDTH : address width of every port
//   DATA_WIDTH : data width; byte enables are DATA_WIDTH/8 bits
// -----------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Instruction-fetch requester
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_WIDTH-1:0] i_rdata;

    // Load/store requester
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [BE_WIDTH-1:0]   d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    // Shared memory port
    logic                  m_req;
    logic                  m_we;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [BE_WIDTH-1:0]   m_be;
    logic                  m_gnt;
    logic                  m_rvalid;
    logic [DATA_WIDTH-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_gnt, m_rvalid, m_rdata
    );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pick
//
// Purpose : Combinational winner select between the fetch and load/store
//           requesters.
//
// Configuration macro: MEM_ARBITER_RR_EN
//   defined   : round-robin; on a tie the requester that is not i_owner (the
//               last one granted) wins.
//   undefined : fixed priority, load/store over fetch; i_owner is not used.
//
// Ports:
//   i_fetch_req : fetch request pending
//   i_data_req  : load/store request pending
//   i_owner     : owner of the most recently granted transaction
//   o_valid     : at least one request pending
//   o_winner    : selected requester (meaningful only when o_valid)
// -----------------------------------------------------------------------------
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic   i_fetch_req,
    input  logic   i_data_req,
    input  owner_t i_owner,
    output logic   o_valid,
    output owner_t o_winner
);

`ifdef MEM_ARBITER_RR_EN
    always_comb begin
        o_valid = i_fetch_req | i_data_req;
        if (i_fetch_req && i_data_req) begin
            // Tie: hand the port to whoever did not have it last.
            o_winner = (i_owner == OWN_D) ? OWN_I : OWN_D;
        end else begin
            o_winner = i_data_req ? OWN_D : OWN_I;
        end
    end
`else
    // Owner history does not matter for fixed priority.
    owner_t w_unused_owner;
    assign w_unused_owner = i_owner;

    always_comb begin
        o_valid  = i_fetch_req | i_data_req;
        o_winner = i_data_req ? OWN_D : OWN_I;
    end
`endif

endmodule : mem_arbiter_pick

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose : Shares the single memory port between instruction fetch (I) and
//           load/store (D). One transaction is outstanding at a time. The
//           winner's fields are latched onto the memory port, and the memory
//           response is steered back to the owning requester while the other
//           requester's rdata is cleared. All outputs are registered.
//
// Configuration macro: MEM_ARBITER_RR_EN (round-robin instead of fixed
//   D-over-I priority; the choice lives in mem_arbiter_pick).
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave
//           i_*  fetch request/grant/response
//           d_*  load/store request/grant/response
//           m_*  memory request (held until m_gnt) and response
//
// Timing (zero-wait memory): request seen at edge N -> gnt/m_req in cycle
//   N+1; m_gnt at edge K -> m_req low in K+1; m_rvalid at edge R -> rvalid and
//   rdata in R+1 with the FSM back in IDLE.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // FSM and ownership
    state_t                r_state,    w_state_nxt;
    owner_t                r_owner,    w_owner_nxt;

    // Memory-port request registers
    logic                  r_m_req,    w_m_req_nxt;
    logic                  r_m_we,     w_m_we_nxt;
    logic [ADDR_WIDTH-1:0] r_m_addr,   w_m_addr_nxt;
    logic [DATA_WIDTH-1:0] r_m_wdata,  w_m_wdata_nxt;
    logic [BE_WIDTH-1:0]   r_m_be,     w_m_be_nxt;

    // Requester-side outputs
    logic                  r_i_gnt,    w_i_gnt_nxt;
    logic                  r_d_gnt,    w_d_gnt_nxt;
    logic                  r_i_rvalid, w_i_rvalid_nxt;
    logic                  r_d_rvalid, w_d_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_i_rdata,  w_i_rdata_nxt;
    logic [DATA_WIDTH-1:0] r_d_rdata,  w_d_rdata_nxt;

    logic                  w_pick_valid;
    owner_t                w_pick_owner;
    logic                  w_respond;
    logic [DATA_WIDTH-1:0] w_resp_data;

    mem_arbiter_pick u_pick (
        .i_fetch_req (bus.i_req),
        .i_data_req  (bus.d_req),
        .i_owner     (r_owner),
        .o_valid     (w_pick_valid),
        .o_winner    (w_pick_owner)
    );

    // A write is acknowledged with zero data, whatever memory puts on m_rdata.
    assign w_resp_data = r_m_we ? '0 : bus.m_rdata;

    always_comb begin
        // NOTE: every signal written here gets a default first; any path that
        // skipped an assignment would otherwise infer a latch.
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_m_req_nxt    = r_m_req;
        w_m_we_nxt     = r_m_we;
        w_m_addr_nxt   = r_m_addr;
        w_m_wdata_nxt  = r_m_wdata;
        w_m_be_nxt     = r_m_be;
        w_i_gnt_nxt    = 1'b0;
        w_d_gnt_nxt    = 1'b0;
        w_i_rvalid_nxt = 1'b0;
        w_d_rvalid_nxt = 1'b0;
        w_i_rdata_nxt  = r_i_rdata;
        w_d_rdata_nxt  = r_d_rdata;
        w_respond      = 1'b0;

        case (r_state)
            IDLE: begin
                // m_rvalid is deliberately ignored here: nothing is outstanding.
                if (w_pick_valid) begin
                    w_owner_nxt = w_pick_owner;
                    w_m_req_nxt = 1'b1;
                    w_state_nxt = REQ;
                    if (w_pick_owner == OWN_D) begin
                        w_d_gnt_nxt   = 1'b1;
                        w_m_we_nxt    = bus.d_we;
                        w_m_addr_nxt  = bus.d_addr;
                        w_m_wdata_nxt = bus.d_wdata;
                        w_m_be_nxt    = bus.d_be;
                    end else begin
                        // Fetches are always full-width reads.
                        w_i_gnt_nxt   = 1'b1;
                        w_m_we_nxt    = 1'b0;
                        w_m_addr_nxt  = bus.i_addr;
                        w_m_wdata_nxt = '0;
                        w_m_be_nxt    = '1;
                    end
                end
            end

            REQ: begin
                // A response can only belong to this request once it is accepted.
                if (bus.m_gnt) begin
                    w_m_req_nxt = 1'b0;
                    if (bus.m_rvalid) begin
                        w_respond   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end

            WAIT: begin
                if (bus.m_rvalid) begin
                    w_respond   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_respond) begin
            if (r_owner == OWN_D) begin
                w_d_rvalid_nxt = 1'b1;
                w_d_rdata_nxt  = w_resp_data;
                w_i_rdata_nxt  = '0;
            end else begin
                w_i_rvalid_nxt = 1'b1;
                w_i_rdata_nxt  = w_resp_data;
                w_d_rdata_nxt  = '0;
            end
        end
    end

    // NOTE: the datapath registers are reset along with the control state
    // because every output must read zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= OWN_D;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_be     <= '0;
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_m_req    <= w_m_req_nxt;
            r_m_we     <= w_m_we_nxt;
            r_m_addr   <= w_m_addr_nxt;
            r_m_wdata  <= w_m_wdata_nxt;
            r_m_be     <= w_m_be_nxt;
            r_i_gnt    <= w_i_gnt_nxt;
            r_d_gnt    <= w_d_gnt_nxt;
            r_i_rvalid <= w_i_rvalid_nxt;
            r_d_rvalid <= w_d_rvalid_nxt;
            r_i_rdata  <= w_i_rdata_nxt;
            r_d_rdata  <= w_d_rdata_nxt;
        end
    end

    assign bus.m_req    = r_m_req;
    assign bus.m_we     = r_m_we;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.m_be     = r_m_be;
    assign bus.i_gnt    = r_i_gnt;
    assign bus.d_gnt    = r_d_gnt;
    assign bus.i_rvalid = r_i_rvalid;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.d_rdata  = r_d_rdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose : Directed self-checking bench for mem_arbiter. Inputs are driven
//           1 time unit after the rising edge and registered outputs are
//           checked at that same point, so every step below is one clock.
//
// Configuration macro: MEM_ARBITER_RR_EN selects the expected arbitration order.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requesters must hold req until granted; flag any early drop.
    bit i_pend = 1'b0;
    bit d_pend = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            assert (!(i_pend && !bus.i_req && !bus.i_gnt)) else begin
                bad++;
                $error("FAIL proto_i_req_drop: observed=0 expected=1");
            end
            total++;
            assert (!(d_pend && !bus.d_req && !bus.d_gnt)) else begin
                bad++;
                $error("FAIL proto_d_req_drop: observed=0 expected=1");
            end
            i_pend = bus.i_req && !bus.i_gnt;
            d_pend = bus.d_req && !bus.d_gnt;
        end else begin
            i_pend = 1'b0;
            d_pend = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One zero-wait transaction: inputs already set; expects 'who' to be granted.
    task automatic do_txn(input owner_t who, input logic [31:0] addr, input logic [31:0] data);
        tick();
        check("arb_i_gnt", bus.i_gnt, who == OWN_I);
        check("arb_d_gnt", bus.d_gnt, who == OWN_D);
        check("arb_m_addr", bus.m_addr, addr);
        if (who == OWN_I) bus.i_req = 1'b0;
        else              bus.d_req = 1'b0;
        bus.m_gnt = 1'b1;
        tick();
        check("arb_m_req_drop", bus.m_req, 1'b0);
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = data;
        tick();
        check("arb_i_rvalid", bus.i_rvalid, who == OWN_I);
        check("arb_d_rvalid", bus.d_rvalid, who == OWN_D);
        check("arb_i_rdata", bus.i_rdata, (who == OWN_I) ? data : 32'h0);
        check("arb_d_rdata", bus.d_rdata, (who == OWN_D) ? data : 32'h0);
        bus.m_rvalid = 1'b0;
    endtask

    initial begin
        owner_t first;
        owner_t second;
`ifdef MEM_ARBITER_RR_EN
        first  = OWN_I;
        second = OWN_D;
`else
        first  = OWN_D;
        second = OWN_I;
`endif
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;

        // ---- Reset state ----
        tick();
        tick();
        check("rst_m_req", bus.m_req, 0);
        check("rst_m_we", bus.m_we, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_m_wdata", bus.m_wdata, 0);
        check("rst_m_be", bus.m_be, 0);
        check("rst_gnt", {bus.i_gnt, bus.d_gnt}, 0);
        check("rst_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
        check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        check("rst_state", dut.r_state, IDLE);
        check("rst_owner", dut.r_owner, OWN_D);
        rst_n = 1'b1;
        tick();

        // ---- Spurious m_rvalid in IDLE ----
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1111_1111;
        tick();
        check("spur_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
        check("spur_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        check("spur_m_req", bus.m_req, 0);
        bus.m_rvalid = 1'b0;

        // ---- Single I read, m_gnt after 2 cycles, response 3 cycles later ----
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        tick();
        check("ird_i_gnt", bus.i_gnt, 1);
        check("ird_d_gnt", bus.d_gnt, 0);
        check("ird_m_req", bus.m_req, 1);
        check("ird_m_addr", bus.m_addr, 32'h100);
        check("ird_m_we", bus.m_we, 0);
        check("ird_m_be", bus.m_be, 4'hF);
        check("ird_m_wdata", bus.m_wdata, 0);
        bus.i_req = 1'b0; bus.i_addr = 32'hFFF;
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h5555_5555;  // no m_gnt: must be ignored
        tick();
        check("ird_gnt_pulse", bus.i_gnt, 0);
        check("ird_m_req_hold", bus.m_req, 1);
        check("ird_addr_latched", bus.m_addr, 32'h100);
        check("ird_rvalid_in_req", bus.i_rvalid, 0);
        bus.m_rvalid = 1'b0; bus.m_gnt = 1'b1;
        tick();
        check("ird_m_req_low", bus.m_req, 0);
        check("ird_state_wait", dut.r_state, WAIT);
        bus.m_gnt = 1'b0;
        tick();
        check("ird_wait1", bus.i_rvalid, 0);
        tick();
        check("ird_wait2", bus.i_rvalid, 0);
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
        tick();
        check("ird_i_rvalid", bus.i_rvalid, 1);
        check("ird_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        check("ird_d_rvalid", bus.d_rvalid, 0);
        check("ird_d_rdata", bus.d_rdata, 0);
        check("ird_state_idle", dut.r_state, IDLE);
        bus.m_rvalid = 1'b0;
        tick();
        check("ird_rvalid_pulse", bus.i_rvalid, 0);
        check("ird_rdata_hold", bus.i_rdata, 32'hDEAD_BEEF);

        // ---- D write ----
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000;
        bus.d_wdata = 32'h1234_5678; bus.d_be = 4'h3;
        tick();
        check("dwr_d_gnt", bus.d_gnt, 1);
        check("dwr_i_gnt", bus.i_gnt, 0);
        check("dwr_m_req", bus.m_req, 1);
        check("dwr_m_we", bus.m_we, 1);
        check("dwr_m_addr", bus.m_addr, 32'h2000);
        check("dwr_m_wdata", bus.m_wdata, 32'h1234_5678);
        check("dwr_m_be", bus.m_be, 4'h3);
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = 32'h0; bus.m_gnt = 1'b1;
        tick();
        check("dwr_gnt_pulse", bus.d_gnt, 0);
        check("dwr_m_req_low", bus.m_req, 0);
        check("dwr_wdata_latched", bus.m_wdata, 32'h1234_5678);
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hAAAA_5555;
        tick();
        check("dwr_d_rvalid", bus.d_rvalid, 1);
        check("dwr_d_rdata_zero", bus.d_rdata, 0);
        check("dwr_i_rvalid", bus.i_rvalid, 0);
        check("dwr_i_rdata_clr", bus.i_rdata, 0);
        bus.m_rvalid = 1'b0;
        tick();
        check("dwr_rvalid_pulse", bus.d_rvalid, 0);

        // ---- m_gnt and m_rvalid together in REQ ----
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_be = 4'hF;
        tick();
        check("cmb_d_gnt", bus.d_gnt, 1);
        check("cmb_m_we", bus.m_we, 0);
        bus.d_req = 1'b0; bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFE_F00D;
        tick();
        check("cmb_d_rvalid", bus.d_rvalid, 1);
        check("cmb_d_rdata", bus.d_rdata, 32'hCAFE_F00D);
        check("cmb_m_req", bus.m_req, 0);
        check("cmb_state_idle", dut.r_state, IDLE);
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0;
        tick();
        check("cmb_rvalid_pulse", bus.d_rvalid, 0);

        // ---- Simultaneous requests, 4 back-to-back pairs, zero-wait memory ----
        for (int p = 0; p < 4; p++) begin
            logic [31:0] ia;
            logic [31:0] da;
            ia = 32'h300 + 32'(p * 4);
            da = 32'h400 + 32'(p * 4);
            bus.i_req = 1'b1; bus.i_addr = ia;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = da; bus.d_be = 4'hF;
            do_txn(first,  (first  == OWN_I) ? ia : da, 32'hA000_0000 + 32'(p));
            do_txn(second, (second == OWN_I) ? ia : da, 32'hB000_0000 + 32'(p));
        end
        tick();
        check("arb_idle_after", dut.r_state, IDLE);

        // ---- Reset mid-transaction, then late response ----
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500; bus.d_be = 4'hF;
        tick();
        check("mrst_d_gnt", bus.d_gnt, 1);
        bus.d_req = 1'b0; bus.m_gnt = 1'b1;
        tick();
        check("mrst_state_wait", dut.r_state, WAIT);
        bus.m_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_state", dut.r_state, IDLE);
        check("mrst_m_req", bus.m_req, 0);
        check("mrst_m_addr", bus.m_addr, 0);
        check("mrst_m_be", bus.m_be, 0);
        check("mrst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        tick();
        rst_n = 1'b1;
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
        tick();
        check("late_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
        check("late_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        check("late_m_req", bus.m_req, 0);
        bus.m_rvalid = 1'b0;
        tick();
        check("late_no_pulse", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between the instruction-fetch requester (I) and the load/store requester (D). It keeps exactly one transaction outstanding and latches the chosen request onto the memory port. It then steers the memory response back to the owning requester and drives zero on the other one's response data. It sits between the fetch/LSU stages and the memory bus, and is the sequencing point for the existing 2-way datapath steering.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; must be a multiple of 8
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  ADDR_WIDTH  fetch address
- i_gnt  out  1  one-cycle pulse: fetch request accepted
- i_rvalid  out  1  one-cycle pulse: fetch data valid
- i_rdata  out  DATA_WIDTH  fetch data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_gnt
- d_we  in  1  1 = write
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_be  in  DATA_WIDTH/8  byte enables
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: read data or write acknowledge
- d_rdata  out  DATA_WIDTH  read data; 0 for writes
- m_req  out  1  memory request; held until m_gnt
- m_we, m_addr, m_wdata, m_be  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  latched request fields
- m_gnt  in  1  memory accepted m_req this cycle
- m_rvalid  in  1  memory response; one per accepted request, reads and writes alike
- m_rdata  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT. All outputs are registered.
- IDLE: if any request is pending, pick a winner, latch its fields into the m_* registers, and set owner. Assert the winner's gnt and m_req on the next cycle, then go to REQ. I requests drive m_we=0, m_wdata=0, m_be all-ones.
- Pick rule is fixed priority: D wins over I.
- REQ: hold m_req and all fields. On m_gnt, drop m_req. Go to WAIT, or straight to IDLE with a response if m_rvalid is also high.
- WAIT: on m_rvalid, the owner's rvalid pulses and its rdata takes m_rdata (0 if the transaction was a write). The non-owner's rdata is cleared to 0. Go to IDLE.
- m_rvalid is ignored in IDLE, and in REQ unless m_gnt is also high.
- A requester dropping req before gnt is a protocol violation; the bench asserts on it.
- Fields are latched once, so later changes on the requester inputs do not affect an issued transaction.

## Timing
- Reset (async, rst_n=0): state=IDLE, owner=D. All of m_req, m_we, m_addr, m_wdata, m_be, i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata and d_rdata are 0.
- req high in IDLE at edge N: gnt and m_req are high in cycle N+1.
- m_gnt at edge K: m_req is low in cycle K+1.
- m_rvalid at edge R: the owner's rvalid and rdata appear in cycle R+1, and the FSM is in IDLE that same cycle.
- A new request seen at edge R+1 issues at R+2. Minimum period is 3 cycles per transaction when memory has zero wait.
- Reset mid-transaction abandons the transaction. No gnt or rvalid is produced for it, and a late m_rvalid is ignored in IDLE.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin arbitration. On simultaneous requests, the requester that is not `owner` (the last granted) wins. The reset value owner=D means I wins the first tie.
- MEM_ARBITER_RR_EN undefined: fixed D-over-I priority; owner is used only for response steering.

## Structure
- Package mem_arbiter_pkg contains:
  - the state enum typedef (IDLE, REQ, WAIT);
  - the owner enum typedef (OWN_I, OWN_D);
  - the localparam for the default data width.
- One sub-module, mem_arbiter_pick: combinational winner select from i_req, d_req and owner. The RR/fixed choice under MEM_ARBITER_RR_EN lives here.

## Test plan
- Reset: assert rst_n=0 during traffic -> all outputs 0 and state IDLE within the same cycle, with no pulses after release.
- Single I read: i_req, i_addr=0x100, memory m_gnt after 2 cycles, m_rvalid with 0xDEADBEEF 3 cycles later -> i_gnt one pulse, m_addr=0x100, m_we=0, i_rvalid one pulse with i_rdata=0xDEADBEEF, d_rdata=0.
- D write: d_addr=0x2000, d_wdata=0x12345678, d_be=0x3 -> m_we=1 with fields matching, d_rvalid pulse, d_rdata=0.
- Simultaneous i_req and d_req held, zero-wait memory:
  - without the macro, D is granted first, then I;
  - with MEM_ARBITER_RR_EN, I first, then D, and grants alternate on 4 back-to-back pairs.
- m_gnt and m_rvalid in the same cycle in REQ -> response delivered the next cycle, no extra WAIT cycle.
- Spurious m_rvalid in IDLE, and a late response after mid-transaction reset -> no rvalid on either requester.
